// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: requester handshake and CDB bundle between execution units and the ROB writeback arbiter
interface cdb_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ROB_IDX_W = 4,
  parameter int SRC_W     = 2
);
  logic                      rdy_in;
  logic                      clear_branch_in;
  logic [NREQ-1:0]           req_valid_in;
  logic [NREQ-1:0]           req_ready_out;
  logic [NREQ*ROB_IDX_W-1:0] req_rob_pos_in;
  logic [NREQ*WORD_W-1:0]    req_res_in;
  logic [NREQ-1:0]           req_jump_en_in;
  logic [NREQ*ADDR_W-1:0]    req_jump_a_in;
  logic                      cdb_en_out;
  logic [ROB_IDX_W-1:0]      cdb_rob_pos_out;
  logic [WORD_W-1:0]         cdb_res_out;
  logic                      cdb_jump_en_out;
  logic [ADDR_W-1:0]         cdb_jump_a_out;
  logic [SRC_W-1:0]          cdb_src_out;
  logic [3:0]                pending_out;
  modport master (
    output rdy_in, clear_branch_in, req_valid_in, req_rob_pos_in, req_res_in, req_jump_en_in, req_jump_a_in,
    input  req_ready_out, cdb_en_out, cdb_rob_pos_out, cdb_res_out, cdb_jump_en_out, cdb_jump_a_out,
           cdb_src_out, pending_out
  );
  modport slave (
    input  rdy_in, clear_branch_in, req_valid_in, req_rob_pos_in, req_res_in, req_jump_en_in, req_jump_a_in,
    output req_ready_out, cdb_en_out, cdb_rob_pos_out, cdb_res_out, cdb_jump_en_out, cdb_jump_a_out,
           cdb_src_out, pending_out
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin share of the ROB writeback port among NREQ one-entry holding buffers, registered CDB output
module cdb_arbiter #(
  parameter int NREQ      = 4,
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int ROB_IDX_W = 4,
  parameter int SRC_W     = 2
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  cdb_arbiter_if.slave bus
);
  logic [NREQ-1:0]                buf_v, buf_je, grant, ready, accept;
  logic [NREQ-1:0][ROB_IDX_W-1:0] buf_pos;
  logic [NREQ-1:0][WORD_W-1:0]    buf_res;
  logic [NREQ-1:0][ADDR_W-1:0]    buf_ja;
  logic [SRC_W-1:0]               rr_ptr, gnt_idx, lo_idx, hi_idx, cdb_src;
  logic                           found, hi_found, cdb_en, cdb_je;
  logic [ROB_IDX_W-1:0]           cdb_pos;
  logic [WORD_W-1:0]              cdb_res;
  logic [ADDR_W-1:0]              cdb_ja;
  // descending scan leaves the lowest valid index overall and the lowest at or above rr_ptr
  always_comb begin
    found = 1'b0;
    hi_found = 1'b0;
    lo_idx = '0;
    hi_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (buf_v[i]) begin
        found = 1'b1;
        lo_idx = SRC_W'(i);
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx = SRC_W'(i);
        end
      end
    end
    gnt_idx = hi_found ? hi_idx : lo_idx;
    grant = found ? (NREQ'(1) << gnt_idx) : '0;
  end
  assign ready  = {NREQ{rst_n_in && bus.rdy_in && !bus.clear_branch_in}} & (~buf_v | grant);
  assign accept = ready & bus.req_valid_in;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      buf_v <= '0;
      buf_je <= '0;
      buf_pos <= '0;
      buf_res <= '0;
      buf_ja <= '0;
      rr_ptr <= '0;
      cdb_en <= 1'b0;
      cdb_pos <= '0;
      cdb_res <= '0;
      cdb_je <= 1'b0;
      cdb_ja <= '0;
      cdb_src <= '0;
    end else if (bus.rdy_in) begin
      if (bus.clear_branch_in) begin
        buf_v <= '0;
        cdb_en <= 1'b0;
        rr_ptr <= '0;
      end else begin
        cdb_en <= found;
        if (found) begin
          cdb_pos <= buf_pos[gnt_idx];
          cdb_res <= buf_res[gnt_idx];
          cdb_je <= buf_je[gnt_idx];
          cdb_ja <= buf_ja[gnt_idx];
          cdb_src <= gnt_idx;
          rr_ptr <= (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
        end
        for (int i = 0; i < NREQ; i++) begin
          if (accept[i]) begin
            buf_v[i] <= 1'b1;
            buf_pos[i] <= bus.req_rob_pos_in[i*ROB_IDX_W +: ROB_IDX_W];
            buf_res[i] <= bus.req_res_in[i*WORD_W +: WORD_W];
            buf_je[i] <= bus.req_jump_en_in[i];
            buf_ja[i] <= bus.req_jump_a_in[i*ADDR_W +: ADDR_W];
          end else if (grant[i]) begin
            buf_v[i] <= 1'b0;
          end
        end
      end
    end
  end
  assign bus.req_ready_out   = ready;
  assign bus.pending_out     = 4'($countones(buf_v));
  assign bus.cdb_en_out      = cdb_en;
  assign bus.cdb_rob_pos_out = cdb_pos;
  assign bus.cdb_res_out     = cdb_res;
  assign bus.cdb_jump_en_out = cdb_je;
  assign bus.cdb_jump_a_out  = cdb_ja;
  assign bus.cdb_src_out     = cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios plus random traffic against a per-cycle behavioural model of the CDB arbiter
module tb_cdb_arbiter;
  localparam int N = 4;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;
  cdb_arbiter_if bus();
  cdb_arbiter dut (.clk_in(clk_in), .rst_n_in(rst_n_in), .bus(bus));
  int compared = 0;
  int mismatched = 0;
  typedef struct packed {logic [3:0] pos; logic [31:0] res; logic je; logic [31:0] ja;} ent_t;
  bit   mv[N];
  ent_t mb[N];
  ent_t mcdb = '0;
  bit   men = 0;
  int   msrc = 0;
  int   mrr = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int winner();
    for (int k = 0; k < N; k++) if (mv[(mrr + k) % N]) return (mrr + k) % N;
    return -1;
  endfunction
  function automatic ent_t req_ent(int i);
    ent_t r;
    r.pos = bus.req_rob_pos_in[i*4 +: 4];
    r.res = bus.req_res_in[i*32 +: 32];
    r.je  = bus.req_jump_en_in[i];
    r.ja  = bus.req_jump_a_in[i*32 +: 32];
    return r;
  endfunction
  always @(posedge clk_in or negedge rst_n_in) begin
    int w;
    bit take[N];
    if (!rst_n_in) begin
      for (int i = 0; i < N; i++) mv[i] = 0;
      men = 0; mcdb = '0; msrc = 0; mrr = 0;
    end else if (bus.rdy_in) begin
      if (bus.clear_branch_in) begin
        for (int i = 0; i < N; i++) mv[i] = 0;
        men = 0; mrr = 0;
      end else begin
        w = winner();
        for (int i = 0; i < N; i++) take[i] = bus.req_valid_in[i] && (!mv[i] || i == w);
        men = (w >= 0);
        if (w >= 0) begin
          mcdb = mb[w]; msrc = w; mrr = (w + 1) % N; mv[w] = 0;
        end
        for (int i = 0; i < N; i++) if (take[i]) begin mv[i] = 1; mb[i] = req_ent(i); end
      end
    end
  end
  always @(negedge clk_in) begin
    int w, cnt;
    logic [N-1:0] er;
    if (rst_n_in) begin
      w = winner();
      cnt = 0;
      for (int i = 0; i < N; i++) begin
        er[i] = bus.rdy_in && !bus.clear_branch_in && (!mv[i] || i == w);
        cnt += int'(mv[i]);
      end
      chk("m_en", 64'(bus.cdb_en_out), 64'(men));
      chk("m_pos", 64'(bus.cdb_rob_pos_out), 64'(mcdb.pos));
      chk("m_res", 64'(bus.cdb_res_out), 64'(mcdb.res));
      chk("m_je", 64'(bus.cdb_jump_en_out), 64'(mcdb.je));
      chk("m_ja", 64'(bus.cdb_jump_a_out), 64'(mcdb.ja));
      chk("m_src", 64'(bus.cdb_src_out), 64'(msrc));
      chk("m_pending", 64'(bus.pending_out), 64'(cnt));
      chk("m_ready", 64'(bus.req_ready_out), 64'(er));
    end
  end
  task automatic set_req(input int i, input logic [3:0] pos, input logic [31:0] res, input logic je,
                         input logic [31:0] ja);
    bus.req_rob_pos_in[i*4 +: 4] = pos;
    bus.req_res_in[i*32 +: 32] = res;
    bus.req_jump_en_in[i] = je;
    bus.req_jump_a_in[i*32 +: 32] = ja;
  endtask
  initial begin
    bus.rdy_in = 1; bus.clear_branch_in = 0; bus.req_valid_in = '1;
    bus.req_rob_pos_in = '0; bus.req_res_in = '0; bus.req_jump_en_in = '0; bus.req_jump_a_in = '0;
    repeat (2) @(negedge clk_in);
    chk("rst_ready", 64'(bus.req_ready_out), 64'h0);
    chk("rst_en", 64'(bus.cdb_en_out), 64'h0);
    chk("rst_pending", 64'(bus.pending_out), 64'h0);
    #1 rst_n_in = 1; bus.req_valid_in = 4'b0001; set_req(0, 4'd3, 32'hAA, 1'b0, 32'h0);
    @(negedge clk_in);
    chk("lat_pending", 64'(bus.pending_out), 64'd1);
    chk("lat_en0", 64'(bus.cdb_en_out), 64'd0);
    #1 bus.req_valid_in = '0;
    @(negedge clk_in);
    chk("lat_en1", 64'(bus.cdb_en_out), 64'd1);
    chk("lat_pos", 64'(bus.cdb_rob_pos_out), 64'd3);
    chk("lat_res", 64'(bus.cdb_res_out), 64'hAA);
    chk("lat_src", 64'(bus.cdb_src_out), 64'd0);
    @(negedge clk_in);
    chk("lat_en_off", 64'(bus.cdb_en_out), 64'd0);
    #1 bus.clear_branch_in = 1;
    @(negedge clk_in);
    #1 bus.clear_branch_in = 0; bus.req_valid_in = 4'b1111;
    for (int i = 0; i < N; i++) set_req(i, 4'(i + 1), 32'h100 + 32'(i), 1'b0, 32'h0);
    @(negedge clk_in);
    chk("rr_fill", 64'(bus.pending_out), 64'd4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_in);
      chk("rr_src", 64'(bus.cdb_src_out), 64'(k % 4));
      chk("rr_pos", 64'(bus.cdb_rob_pos_out), 64'(k % 4 + 1));
      chk("rr_en", 64'(bus.cdb_en_out), 64'd1);
      chk("rr_ready", 64'(bus.req_ready_out), 64'(4'b0001 << ((k + 1) % 4)));
    end
    #1 bus.clear_branch_in = 1;
    @(negedge clk_in);
    chk("fl_en", 64'(bus.cdb_en_out), 64'd0);
    chk("fl_pending", 64'(bus.pending_out), 64'd0);
    #1 bus.clear_branch_in = 0; bus.req_valid_in = 4'b0111;
    for (int i = 0; i < 3; i++) set_req(i, 4'(i + 1), 32'h200 + 32'(i), 1'b0, 32'h0);
    @(negedge clk_in);
    chk("bp_ready_a", 64'(bus.req_ready_out[2]), 64'd0);
    chk("bp_pending", 64'(bus.pending_out), 64'd3);
    #1 bus.req_valid_in = 4'b0100; set_req(2, 4'd7, 32'h777, 1'b1, 32'hCAFE);
    @(negedge clk_in);
    chk("bp_ready_b", 64'(bus.req_ready_out[2]), 64'd0);
    chk("bp_src_b", 64'(bus.cdb_src_out), 64'd0);
    @(negedge clk_in);
    chk("bp_ready_c", 64'(bus.req_ready_out[2]), 64'd1);
    @(negedge clk_in);
    chk("bp_pos_d", 64'(bus.cdb_rob_pos_out), 64'd3);
    chk("bp_src_d", 64'(bus.cdb_src_out), 64'd2);
    #1 bus.req_valid_in = 4'b0001; set_req(0, 4'd5, 32'h555, 1'b0, 32'h0);
    @(negedge clk_in);
    chk("bp_pos_e", 64'(bus.cdb_rob_pos_out), 64'd7);
    chk("bp_ja_e", 64'(bus.cdb_jump_a_out), 64'hCAFE);
    #1 bus.req_valid_in = 4'b0010; set_req(1, 4'd6, 32'h666, 1'b0, 32'h0);
    @(negedge clk_in);
    chk("st_pos", 64'(bus.cdb_rob_pos_out), 64'd5);
    #1 bus.rdy_in = 0; bus.req_valid_in = 4'b1111;
    repeat (3) begin
      @(negedge clk_in);
      chk("st_en", 64'(bus.cdb_en_out), 64'd1);
      chk("st_hold", 64'(bus.cdb_rob_pos_out), 64'd5);
      chk("st_ready", 64'(bus.req_ready_out), 64'd0);
      chk("st_pending", 64'(bus.pending_out), 64'd1);
    end
    #1 bus.rdy_in = 1; bus.req_valid_in = '0;
    @(negedge clk_in);
    chk("st_next_pos", 64'(bus.cdb_rob_pos_out), 64'd6);
    chk("st_next_src", 64'(bus.cdb_src_out), 64'd1);
    #1 bus.req_valid_in = 4'b0011; set_req(0, 4'd8, 32'h8, 1'b0, 32'h0); set_req(1, 4'd9, 32'h9, 1'b0, 32'h0);
    @(negedge clk_in);
    chk("ar_pending", 64'(bus.pending_out), 64'd2);
    #1 bus.req_valid_in = '0;
    @(posedge clk_in);
    #3 rst_n_in = 0;
    #1;
    chk("ar_en", 64'(bus.cdb_en_out), 64'd0);
    chk("ar_pend", 64'(bus.pending_out), 64'd0);
    chk("ar_ready", 64'(bus.req_ready_out), 64'd0);
    @(negedge clk_in);
    #1 rst_n_in = 1; bus.req_valid_in = 4'b1111;
    @(negedge clk_in);
    #1 bus.req_valid_in = '0;
    @(negedge clk_in);
    chk("ar_first_src", 64'(bus.cdb_src_out), 64'd0);
    chk("ar_first_en", 64'(bus.cdb_en_out), 64'd1);
    repeat (3000) begin
      @(negedge clk_in);
      #1;
      bus.rdy_in = ($urandom % 8) != 0;
      bus.clear_branch_in = ($urandom % 32) == 0;
      bus.req_valid_in = 4'($urandom);
      for (int i = 0; i < N; i++) set_req(i, 4'($urandom), $urandom, 1'($urandom), $urandom);
    end
    @(negedge clk_in);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
